// File: rtl/sci_rx_param.sv
// Parametrised async serial receiver (DATA_BITS, OVERSAMPLE, PARITY, STOP_BITS) on the oversampled baud clock.
// Latency: word committed on the baud_clk edge that takes the final stop-bit sample.
// Backpressure: rx_valid held until rx_ack; a frame finishing while a word is held sets sticky rx_overrun.
module sci_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 7,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 baud_clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int HALF  = (OVERSAMPLE - 1) / 2;
  localparam int CNT_W = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // Line synchroniser plus one delay stage for edge detection.
  logic sync1_q, rxd_s_q, rxd_d_q;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_ovr_q, rx_ovr_d;

  logic start_det;
  logic mid_bit;
  logic commit;
  logic frame_ferr;

  assign start_det = rxd_d_q & ~rxd_s_q;
  assign mid_bit   = (cnt_q == CNT_W'(OVERSAMPLE - 1));

  // Synchroniser flops preset to idle-high so reset never looks like a start edge.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
      rxd_d_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxd_s_q <= sync1_q;
      rxd_d_q <= rxd_s_q;
    end
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: mid-bit sampling of start, data, parity and stop bits.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    commit     = 1'b0;
    frame_ferr = ferr_q;
    case (state_q)
      S_IDLE: begin
        if (start_det) begin
          cnt_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CNT_W'(HALF)) begin
          cnt_d = '0;
          idx_d = '0;
          // A line that is already high again at mid-start was a glitch.
          state_d = rxd_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (mid_bit) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
          if (idx_q == 4'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (mid_bit) begin
          cnt_d   = '0;
          perr_d  = (PARITY == 1) ? (^shift_q ^ rxd_s_q) : ~(^shift_q ^ rxd_s_q);
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (mid_bit) begin
          cnt_d      = '0;
          frame_ferr = ferr_q | ~rxd_s_q;
          ferr_d     = frame_ferr;
          if (idx_q == 4'(STOP_BITS - 1)) begin
            idx_d   = '0;
            commit  = 1'b1;
            // After a framing error the line may be in break; wait for it to go idle.
            state_d = frame_ferr ? S_WAIT_IDLE : S_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output handshake: commit loads when the slot is free or freed by a same-tick ack.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_ovr_d   = rx_ovr_q;
    if (commit) begin
      if (!rx_valid_q || rx_ack) begin
        rx_data_d  = shift_q;
        rx_perr_d  = perr_q;
        rx_ferr_d  = frame_ferr;
        rx_valid_d = 1'b1;
        rx_ovr_d   = 1'b0;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ack) begin
      rx_valid_d = 1'b0;
      rx_perr_d  = 1'b0;
      rx_ferr_d  = 1'b0;
      rx_ovr_d   = 1'b0;
    end
  end

  // Output word and status registers.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;
  assign rx_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sci_rx_param.sv
// Directed bench for sci_rx_param: default 8N1, even parity, and 5-bit/16x/2-stop instances.
// Frames are driven bit by bit with hand-computed expected words and flags.
// Handshake, overrun, break recovery and mid-frame reset are exercised.
module tb_sci_rx_param;

  logic baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  logic rst;
  logic rxd_a, rxd_b, rxd_c;
  logic ack_a, ack_b, ack_c;

  logic [7:0] data_a, data_b;
  logic [4:0] data_c;
  logic valid_a, perr_a, ferr_a, ovr_a, busy_a;
  logic valid_b, perr_b, ferr_b, ovr_b, busy_b;
  logic valid_c, perr_c, ferr_c, ovr_c, busy_c;

  int total = 0;
  int bad   = 0;

  sci_rx_param u_dut_a (
    .baud_clk(baud_clk), .rst(rst), .rxd(rxd_a), .rx_ack(ack_a),
    .rx_data(data_a), .rx_valid(valid_a), .rx_parity_err(perr_a),
    .rx_frame_err(ferr_a), .rx_overrun(ovr_a), .rx_busy(busy_a)
  );

  sci_rx_param #(.DATA_BITS(8), .OVERSAMPLE(7), .PARITY(1), .STOP_BITS(1)) u_dut_b (
    .baud_clk(baud_clk), .rst(rst), .rxd(rxd_b), .rx_ack(ack_b),
    .rx_data(data_b), .rx_valid(valid_b), .rx_parity_err(perr_b),
    .rx_frame_err(ferr_b), .rx_overrun(ovr_b), .rx_busy(busy_b)
  );

  sci_rx_param #(.DATA_BITS(5), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(2)) u_dut_c (
    .baud_clk(baud_clk), .rst(rst), .rxd(rxd_c), .rx_ack(ack_c),
    .rx_data(data_c), .rx_valid(valid_c), .rx_parity_err(perr_c),
    .rx_frame_err(ferr_c), .rx_overrun(ovr_c), .rx_busy(busy_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic set_rxd(input int sel, input logic v);
    case (sel)
      0:       rxd_a = v;
      1:       rxd_b = v;
      default: rxd_c = v;
    endcase
  endtask

  task automatic set_ack(input int sel, input logic v);
    case (sel)
      0:       ack_a = v;
      1:       ack_b = v;
      default: ack_c = v;
    endcase
  endtask

  task automatic ack_pulse(input int sel);
    set_ack(sel, 1'b1);
    tick();
    set_ack(sel, 1'b0);
  endtask

  // Line pattern LSB first: start, data bits, optional parity, stop bits.
  function automatic logic [15:0] mk_frame(input logic [8:0] d, input int nd, input int has_par,
                                           input logic pbit, input logic stopv, input int nstop);
    logic [15:0] f;
    int p;
    f = '1;
    p = 0;
    f[p] = 1'b0;
    p++;
    for (int i = 0; i < nd; i++) begin
      f[p] = d[i];
      p++;
    end
    if (has_par != 0) begin
      f[p] = pbit;
      p++;
    end
    for (int i = 0; i < nstop; i++) begin
      f[p] = stopv;
      p++;
    end
    return f;
  endfunction

  // Drives n bits of os ticks each; rx_ack is raised only for drive slot ack_tick.
  task automatic send_frame(input int sel, input int os, input logic [15:0] bits,
                            input int n, input int ack_tick);
    int t;
    t = 0;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < os; j++) begin
        set_rxd(sel, bits[k]);
        set_ack(sel, t == ack_tick);
        tick();
        t++;
      end
    end
    set_ack(sel, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    rxd_a = 1'b1; rxd_b = 1'b1; rxd_c = 1'b1;
    ack_a = 1'b0; ack_b = 1'b0; ack_c = 1'b0;
    #2;
    check_eq("rst_data_a", data_a, 8'h00);
    check_eq("rst_valid_a", valid_a, 1'b0);
    check_eq("rst_busy_a", busy_a, 1'b0);
    check_eq("rst_ovr_a", ovr_a, 1'b0);
    check_eq("rst_valid_c", valid_c, 1'b0);
    tick(); tick();
    rst = 1'b0;
    repeat (4) tick();

    // 0xA5 8N1, ack three ticks after valid
    send_frame(0, 7, mk_frame(9'h0A5, 8, 0, 1'b0, 1'b1, 1), 10, -1);
    check_eq("a5_data", data_a, 8'hA5);
    check_eq("a5_valid", valid_a, 1'b1);
    check_eq("a5_perr", perr_a, 1'b0);
    check_eq("a5_ferr", ferr_a, 1'b0);
    check_eq("a5_ovr", ovr_a, 1'b0);
    check_eq("a5_busy", busy_a, 1'b0);
    tick(); tick();
    check_eq("a5_valid_held", valid_a, 1'b1);
    ack_pulse(0);
    check_eq("a5_valid_after_ack", valid_a, 1'b0);

    // Two-tick glitch rejected in START
    repeat (4) tick();
    rxd_a = 1'b0;
    tick(); tick();
    rxd_a = 1'b1;
    tick();
    check_eq("glitch_busy", busy_a, 1'b1);
    repeat (6) tick();
    check_eq("glitch_idle", busy_a, 1'b0);
    check_eq("glitch_no_valid", valid_a, 1'b0);
    repeat (4) tick();
    send_frame(0, 7, mk_frame(9'h03C, 8, 0, 1'b0, 1'b1, 1), 10, -1);
    check_eq("3c_data", data_a, 8'h3C);
    check_eq("3c_valid", valid_a, 1'b1);
    check_eq("3c_ferr", ferr_a, 1'b0);
    ack_pulse(0);

    // Even parity on 0x07: parity bit 0 is wrong, 1 is right
    send_frame(1, 7, mk_frame(9'h007, 8, 1, 1'b0, 1'b1, 1), 11, -1);
    check_eq("par_bad_data", data_b, 8'h07);
    check_eq("par_bad_valid", valid_b, 1'b1);
    check_eq("par_bad_perr", perr_b, 1'b1);
    check_eq("par_bad_ferr", ferr_b, 1'b0);
    ack_pulse(1);
    check_eq("par_ack_valid", valid_b, 1'b0);
    check_eq("par_ack_perr", perr_b, 1'b0);
    send_frame(1, 7, mk_frame(9'h007, 8, 1, 1'b1, 1'b1, 1), 11, -1);
    check_eq("par_ok_data", data_b, 8'h07);
    check_eq("par_ok_valid", valid_b, 1'b1);
    check_eq("par_ok_perr", perr_b, 1'b0);
    ack_pulse(1);

    // 0x55 with stop bit low, then a long break
    repeat (4) tick();
    send_frame(0, 7, mk_frame(9'h055, 8, 0, 1'b0, 1'b0, 1), 10, -1);
    check_eq("brk_data", data_a, 8'h55);
    check_eq("brk_valid", valid_a, 1'b1);
    check_eq("brk_ferr", ferr_a, 1'b1);
    check_eq("brk_perr", perr_a, 1'b0);
    check_eq("brk_busy", busy_a, 1'b1);
    ack_pulse(0);
    repeat (30 * 7) tick();
    check_eq("brk_still_waiting", busy_a, 1'b1);
    check_eq("brk_no_frame", valid_a, 1'b0);
    rxd_a = 1'b1;
    repeat (4) tick();
    check_eq("brk_released", busy_a, 1'b0);
    repeat (20) tick();
    check_eq("brk_no_frame_after", valid_a, 1'b0);

    // Overrun: 0x11 then 0x22 with no ack
    send_frame(0, 7, mk_frame(9'h011, 8, 0, 1'b0, 1'b1, 1), 10, -1);
    check_eq("ovr_first_data", data_a, 8'h11);
    send_frame(0, 7, mk_frame(9'h022, 8, 0, 1'b0, 1'b1, 1), 10, -1);
    check_eq("ovr_data_kept", data_a, 8'h11);
    check_eq("ovr_flag", ovr_a, 1'b1);
    check_eq("ovr_valid", valid_a, 1'b1);
    ack_pulse(0);
    check_eq("ovr_ack_valid", valid_a, 1'b0);
    check_eq("ovr_ack_flag", ovr_a, 1'b0);
    check_eq("ovr_ack_ferr", ferr_a, 1'b0);
    // Same again, ack lands on the commit tick of 0x22
    send_frame(0, 7, mk_frame(9'h011, 8, 0, 1'b0, 1'b1, 1), 10, -1);
    send_frame(0, 7, mk_frame(9'h022, 8, 0, 1'b0, 1'b1, 1), 10, 69);
    check_eq("same_tick_data", data_a, 8'h22);
    check_eq("same_tick_valid", valid_a, 1'b1);
    check_eq("same_tick_ovr", ovr_a, 1'b0);
    ack_pulse(0);

    // 5 data bits, 16x oversampling, two stop bits
    send_frame(2, 16, mk_frame(9'h01B, 5, 0, 1'b0, 1'b1, 2), 8, -1);
    check_eq("c_1b_data", data_c, 5'h1B);
    check_eq("c_1b_valid", valid_c, 1'b1);
    check_eq("c_1b_ferr", ferr_c, 1'b0);
    check_eq("c_1b_busy", busy_c, 1'b0);
    // Reset during data bit 3 of a frame, held word still pending
    repeat (8) tick();
    send_frame(2, 16, mk_frame(9'h015, 5, 0, 1'b0, 1'b1, 2), 4, -1);
    rxd_c = 1'b0;
    repeat (8) tick();
    check_eq("c_midframe_busy", busy_c, 1'b1);
    rxd_c = 1'b1;
    rst   = 1'b1;
    #1;
    check_eq("c_rst_valid", valid_c, 1'b0);
    check_eq("c_rst_data", data_c, 5'h00);
    check_eq("c_rst_busy", busy_c, 1'b0);
    check_eq("c_rst_ovr", ovr_c, 1'b0);
    tick(); tick(); tick();
    rst = 1'b0;
    repeat (20) tick();
    check_eq("c_post_rst_idle", busy_c, 1'b0);
    check_eq("c_post_rst_valid", valid_c, 1'b0);
    send_frame(2, 16, mk_frame(9'h00A, 5, 0, 1'b0, 1'b1, 2), 8, -1);
    check_eq("c_0a_data", data_c, 5'h0A);
    check_eq("c_0a_valid", valid_c, 1'b1);
    check_eq("c_0a_ferr", ferr_c, 1'b0);
    check_eq("c_0a_ovr", ovr_c, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sci_rx_param.md
Name: sci_rx_param

Overview:
Parametrised UART/SCI receiver, successor to the fixed 8N1 receiver in the IO path of NN_CORE. It runs on the oversampled baud clock. Data width, oversampling ratio, parity mode and stop-bit count are configurable. The block adds parity checking, framing-error recovery, false-start rejection, and a valid/ack output handshake with overrun detection. It feeds the command/weight loader that sits downstream of the serial port.

Parameters:
DATA_BITS, 8, payload bits per frame, 5..9, sent LSB first
OVERSAMPLE, 7, baud_clk ticks per bit period, 4..16
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits checked, 1 or 2

Ports:
baud_clk  in  1  oversampling clock, OVERSAMPLE ticks per bit
rst  in  1  asynchronous reset, active-high
rxd  in  1  serial line, idle high, asynchronous to baud_clk
rx_ack  in  1  consumer accepts the current word while rx_valid=1
rx_data  out  DATA_BITS  received payload, held stable while rx_valid=1
rx_valid  out  1  word available, held until acknowledged
rx_parity_err  out  1  parity mismatch on the current word
rx_frame_err  out  1  stop bit sampled low on the current word
rx_overrun  out  1  a frame completed while rx_valid=1; sticky until ack
rx_busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, rst=1): all outputs 0; FSM to IDLE; counters and shift register 0; synchroniser flops preset to 1.
- rxd passes through a 2-flop synchroniser, giving rxd_s. A third flop holds rxd_s delayed by one tick (rxd_d). Start detect = rxd_d & ~rxd_s.
- HALF = (OVERSAMPLE-1)/2, using integer division.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE
  - On start detect: tick counter = 0, go to START.
- START
  - Count HALF ticks, then sample rxd_s.
  - If sample is 0: counter = 0, bit index = 0, go to DATA.
  - If sample is 1: treat as a glitch, return to IDLE, no flags raised.
- DATA
  - Sample once every OVERSAMPLE ticks (mid-bit).
  - Shift right with the new bit entering the MSB, so the first received bit ends in bit 0 after DATA_BITS samples.
  - After DATA_BITS samples, go to PARITY if PARITY≠0, else go to STOP.
- PARITY
  - Sample one bit OVERSAMPLE ticks after the last data sample.
  - Even mode: error if XOR of (data bits, parity bit) = 1.
  - Odd mode: error if that XOR = 0.
- STOP
  - Sample STOP_BITS bits, one every OVERSAMPLE ticks.
  - Any stop sample = 0 sets the local frame-error flag.
  - After the last stop sample: commit the frame (see below).
  - If frame error: go to WAIT_IDLE; else go to IDLE.
- WAIT_IDLE
  - Stay until rxd_s = 1, then go to IDLE.
  - A break (line held low) produces exactly one errored frame and no further frames.
- Commit (registered on the tick after the final stop sample):
  - If rx_valid=0: load rx_data, rx_parity_err, rx_frame_err; set rx_valid=1. The word is delivered even when its error flags are set.
  - If rx_valid=1 and rx_ack=0 on that tick: discard the new frame, set rx_overrun=1, leave rx_data and the error flags unchanged.
  - If rx_valid=1 and rx_ack=1 on that same tick: the ack consumes the old word and the new frame loads; rx_valid stays 1; no overrun.
- Handshake
  - rx_ack while rx_valid=1 clears rx_valid, rx_parity_err, rx_frame_err and rx_overrun on the next tick.
  - rx_ack while rx_valid=0 is ignored.
- Reception continues regardless of rx_valid. A new start edge may be detected on the tick after the return to IDLE.
- Reset asserted mid-frame aborts the frame and discards the partial word. After release, reception resumes only on a fresh start edge.

Test Plan:
- Default parameters, send 0xA5 as 8N1, ack 3 ticks after rx_valid -> rx_data=0xA5, all error flags 0, rx_valid high until the tick after ack, rx_busy low afterwards.
- rxd low for 2 ticks, then high -> START rejects the glitch; rx_valid stays 0; FSM returns to IDLE; a following 0x3C frame is received correctly.
- PARITY=1, send 0x07 with parity bit 0 (correct is 1) -> rx_data=0x07, rx_valid=1, rx_parity_err=1; repeat with parity bit 1 -> rx_parity_err=0.
- Send 0x55 with stop bit 0, then hold rxd low for 30 bit times, then release -> one word 0x55 with rx_frame_err=1; no further frames; FSM leaves WAIT_IDLE only after rxd returns high.
- Send 0x11 then 0x22 with no ack -> rx_data=0x11, rx_overrun=1. Ack -> all flags clear. Repeat with ack on the exact commit tick of 0x22 -> rx_data=0x22, rx_valid=1, no overrun.
- DATA_BITS=5, OVERSAMPLE=16, STOP_BITS=2, send 0x1B; separately assert rst during bit 3 of a frame -> 0x1B received; reset zeroes all outputs; the next 0x0A frame is received intact.
